// File: rtl/bnn_pkg.sv
// Shared types and helpers for the BNN parameter loader: FSM state encoding,
// byte widths and the chain-length computation.
package bnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BYTE_CNT_W = 4;

    function automatic int unsigned chain_bits(input int unsigned neurons,
                                               input int unsigned inputs,
                                               input int unsigned bias_bits);
        return neurons * (inputs + bias_bits);
    endfunction

endpackage

// File: rtl/bnn_param_loader_if.sv
// Configuration byte stream (valid/ready) between the host side and the loader.
interface bnn_param_loader_if;
    import bnn_pkg::*;

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, in_valid, input in_ready);
    modport slave  (input in_data, in_valid, output in_ready);

endinterface

// File: rtl/bnn_readback_collector.sv
// Collects old chain bits falling out of the tail into bytes, MSB first,
// left-aligning the final partial group. Used only with PARAM_READBACK_EN.
module bnn_readback_collector
    import bnn_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              bit_in,
    input  logic              last,
    output logic [BYTE_W-1:0] rb_data,
    output logic              rb_valid
);

    logic [BYTE_W-1:0]     col;
    logic [BYTE_W-1:0]     col_c;
    logic [BYTE_CNT_W-1:0] cnt;
    logic [BYTE_CNT_W-1:0] cnt_c;

    assign col_c = {col[BYTE_W-2:0], bit_in};
    assign cnt_c = cnt + BYTE_CNT_W'(1);

    // Emit on a full byte or on the final shift of the load, zero-padded low.
    always_ff @(posedge clk) begin
        if (reset) begin
            col      <= '0;
            cnt      <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (shift_en) begin
                if (cnt_c == BYTE_CNT_W'(BYTE_W) || last) begin
                    rb_data  <= col_c << (BYTE_CNT_W'(BYTE_W) - cnt_c);
                    rb_valid <= 1'b1;
                    col      <= '0;
                    cnt      <= '0;
                end else begin
                    col <= col_c;
                    cnt <= cnt_c;
                end
            end
        end
    end

endmodule

// File: rtl/bnn_param_loader.sv
// Serialises configuration bytes into a daisy-chain of binary neurons, one bit
// per clock with setup strobe. Optional readback of old contents: PARAM_READBACK_EN.
module bnn_param_loader
    import bnn_pkg::*;
#(
    parameter int unsigned NEURONS   = 4,
    parameter int unsigned INPUTS    = 8,
    parameter int unsigned BIAS_BITS = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    bnn_param_loader_if.slave cfg,
    output logic              setup,
    output logic              param_out,
    input  logic              chain_in,
    output logic              busy,
    output logic              done,
    output logic [BYTE_W-1:0] rb_data,
    output logic              rb_valid
);

    localparam int unsigned CHAIN_BITS = chain_bits(NEURONS, INPUTS, BIAS_BITS);
    localparam int unsigned BIT_CNT_W  = $clog2(CHAIN_BITS + 1);

    state_t state;
    state_t next_state;

    logic [BYTE_W-1:0]     sr;
    logic [BYTE_W-1:0]     sr_nxt;
    logic [BYTE_CNT_W-1:0] byte_bits;
    logic [BYTE_CNT_W-1:0] byte_bits_nxt;
    logic [BIT_CNT_W-1:0]  sent;
    logic [BIT_CNT_W-1:0]  sent_nxt;
    logic [BIT_CNT_W-1:0]  remain_c;
    logic [BYTE_CNT_W-1:0] first_bits_c;
    logic                  accept_c;
    logic                  last_bit_c;
    logic                  last_shift_c;
    logic                  ready_nxt;
    logic                  busy_nxt;
    logic                  setup_nxt;
    logic                  pout_nxt;
    logic                  done_nxt;

    assign accept_c     = cfg.in_valid & cfg.in_ready;
    assign remain_c     = BIT_CNT_W'(CHAIN_BITS) - sent;
    assign first_bits_c = (remain_c >= BIT_CNT_W'(BYTE_W)) ? BYTE_CNT_W'(BYTE_W)
                                                           : BYTE_CNT_W'(remain_c);
    assign last_bit_c   = (byte_bits == BYTE_CNT_W'(1));
    assign last_shift_c = (state == ST_SHIFT) && last_bit_c &&
                          (sent + BIT_CNT_W'(1) == BIT_CNT_W'(CHAIN_BITS));

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) next_state = ST_LOAD;
            ST_LOAD:          if (accept_c) next_state = ST_SHIFT;
            ST_SHIFT:         if (last_bit_c) next_state = last_shift_c ? ST_DONE : ST_LOAD;
            default:          next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from the upcoming state so the registers line up with it.
    always_comb begin
        ready_nxt = 1'b0;
        busy_nxt  = 1'b0;
        setup_nxt = 1'b0;
        pout_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (next_state)
            ST_LOAD:  begin ready_nxt = 1'b1; busy_nxt = 1'b1; end
            ST_SHIFT: begin setup_nxt = 1'b1; busy_nxt = 1'b1; pout_nxt = sr_nxt[BYTE_W-1]; end
            ST_DONE:  done_nxt = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        sr_nxt        = sr;
        byte_bits_nxt = byte_bits;
        sent_nxt      = sent;
        case (state)
            ST_IDLE, ST_DONE: if (start) sent_nxt = '0;
            ST_LOAD: if (accept_c) begin
                sr_nxt        = cfg.in_data;
                byte_bits_nxt = first_bits_c;
            end
            ST_SHIFT: begin
                sr_nxt        = {sr[BYTE_W-2:0], 1'b0};
                byte_bits_nxt = byte_bits - BYTE_CNT_W'(1);
                sent_nxt      = sent + BIT_CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr           <= '0;
            byte_bits    <= '0;
            sent         <= '0;
            cfg.in_ready <= 1'b0;
            busy         <= 1'b0;
            setup        <= 1'b0;
            param_out    <= 1'b0;
            done         <= 1'b0;
        end else begin
            sr           <= sr_nxt;
            byte_bits    <= byte_bits_nxt;
            sent         <= sent_nxt;
            cfg.in_ready <= ready_nxt;
            busy         <= busy_nxt;
            setup        <= setup_nxt;
            param_out    <= pout_nxt;
            done         <= done_nxt;
        end
    end

`ifdef PARAM_READBACK_EN
    bnn_readback_collector u_rb (
        .clk      (clk),
        .reset    (reset),
        .shift_en (state == ST_SHIFT),
        .bit_in   (chain_in),
        .last     (last_shift_c),
        .rb_data  (rb_data),
        .rb_valid (rb_valid)
    );
`else
    logic unused_c;
    assign unused_c = chain_in ^ last_shift_c;
    assign rb_data  = '0;
    assign rb_valid = 1'b0;
`endif

endmodule

// File: tb/tb_bnn_param_loader.sv
// Scoreboard bench for bnn_param_loader: a 44-bit and an 11-bit chain instance
// with behavioural chain models, randomized loads, stalls, stray starts and reset.
module tb_bnn_param_loader;
    import bnn_pkg::*;

    localparam int unsigned C0 = chain_bits(4, 8, 3);
    localparam int unsigned C1 = chain_bits(1, 8, 3);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [1:0] start, valid, rdy, setup, pout, chin, busy, done, rbv;
    logic [7:0] din [2];
    logic [7:0] rbd [2];

    bnn_param_loader_if s0 ();
    bnn_param_loader_if s1 ();
    assign s0.in_data  = din[0];
    assign s0.in_valid = valid[0];
    assign rdy[0]      = s0.in_ready;
    assign s1.in_data  = din[1];
    assign s1.in_valid = valid[1];
    assign rdy[1]      = s1.in_ready;

    bnn_param_loader u_dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .cfg(s0),
        .setup(setup[0]), .param_out(pout[0]), .chain_in(chin[0]),
        .busy(busy[0]), .done(done[0]), .rb_data(rbd[0]), .rb_valid(rbv[0])
    );

    bnn_param_loader #(.NEURONS(1), .INPUTS(8), .BIAS_BITS(3)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .cfg(s1),
        .setup(setup[1]), .param_out(pout[1]), .chain_in(chin[1]),
        .busy(busy[1]), .done(done[1]), .rb_data(rbd[1]), .rb_valid(rbv[1])
    );

    // Neuron chains as plain FIFOs: oldest bit at the tail feeds chain_in.
    logic [C0-1:0] chain0 = '0;
    logic [C1-1:0] chain1 = '0;
    assign chin[0] = chain0[C0-1];
    assign chin[1] = chain1[C1-1];
    always @(posedge clk) begin
        if (setup[0]) chain0 <= {chain0[C0-2:0], pout[0]};
        if (setup[1]) chain1 <= {chain1[C1-2:0], pout[1]};
    end

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned sc [2] = '{0, 0};
    bit          q0 [$];
    bit          q1 [$];
    logic [7:0]  rq0 [$];
    logic [7:0]  rq1 [$];
    logic [7:0]  stim [8];
    bit          rb_nz = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_bit(input int s, input bit b);
        if (s == 0) q0.push_back(b); else q1.push_back(b);
    endtask

    function automatic int qsize(input int s);
        return (s == 0) ? (q0.size() + rq0.size()) : (q1.size() + rq1.size());
    endfunction

    // Monitor: pops expected bits/bytes whenever the DUT presents them.
    always @(negedge clk) begin
        bit         ok;
        bit         b;
        logic [7:0] r;
        for (int i = 0; i < 2; i++) begin
            if (setup[i]) begin
                sc[i]++;
                ok = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
                if (ok) begin
                    b = (i == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("param_out%0d", i), 64'(pout[i]), 64'(b));
                end else begin
                    tests++; fails++;
                    $display("FAIL setup_unexpected%0d: setup=1 with no bit pending, required 0", i);
                end
            end
            if (rbv[i]) begin
                ok = (i == 0) ? (rq0.size() > 0) : (rq1.size() > 0);
                if (ok) begin
                    r = (i == 0) ? rq0.pop_front() : rq1.pop_front();
                    check($sformatf("rb_data%0d", i), 64'(rbd[i]), 64'(r));
                end else begin
                    tests++; fails++;
                    $display("FAIL rb_valid_unexpected%0d: rb_valid=1 with rb_data 0x%0h, required 0", i, rbd[i]);
                end
            end
`ifndef PARAM_READBACK_EN
            if (rbd[i] != 8'h00) rb_nz = 1'b1;
`endif
        end
    end

`ifdef PARAM_READBACK_EN
    // Old chain content, oldest bit first, packed into left-aligned bytes.
    task automatic push_rb(input int s, input int cbits);
        logic [63:0] old;
        logic [7:0]  v;
        old = (s == 0) ? 64'(chain0) : 64'(chain1);
        for (int g = 0; g < cbits; g += 8) begin
            v = '0;
            for (int k = 0; k < 8; k++)
                if (g + k < cbits) v[7-k] = old[cbits-1-g-k];
            if (s == 0) rq0.push_back(v); else rq1.push_back(v);
        end
    endtask
`endif

    task automatic drive_byte(input int s, input logic [7:0] b);
        int n = 0;
        din[s]   = b;
        valid[s] = 1'b1;
        while (!rdy[s] && n < 100) begin @(negedge clk); n++; end
        if (!rdy[s]) begin
            tests++; fails++;
            $display("FAIL ready_timeout%0d: in_ready 0 after %0d cycles, required 1", s, n);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_load(input int s, input int stall_at, input int stall_len,
                           input int start_at, input bit chk_lat);
        int          cbits, nb, rem, n;
        int unsigned base;
        logic [63:0] exp_chain;
        time         t_load, t_done;
        cbits     = (s == 0) ? C0 : C1;
        nb        = (cbits + 7) / 8;
        rem       = cbits;
        exp_chain = '0;
        base      = sc[s];
`ifdef PARAM_READBACK_EN
        push_rb(s, cbits);
`endif
        @(negedge clk); start[s] = 1'b1;
        @(negedge clk); start[s] = 1'b0;
        t_load = $time;
        check("ready_in_load", 64'(rdy[s]), 64'd1);
        for (int i = 0; i < nb; i++) begin
            if (i == stall_at) begin
                valid[s] = 1'b0;
                n = 0;
                while (!rdy[s] && n < 100) begin @(negedge clk); n++; end
                for (int k = 0; k < stall_len; k++) begin
                    @(negedge clk);
                    check("stall_setup", 64'(setup[s]), 64'd0);
                    check("stall_ready", 64'(rdy[s]), 64'd1);
                end
            end
            for (int b = 7; b >= 0; b--)
                if (rem > 0) begin
                    push_bit(s, stim[i][b]);
                    exp_chain = {exp_chain[62:0], stim[i][b]};
                    rem--;
                end
            drive_byte(s, stim[i]);
            if (i == start_at) begin start[s] = 1'b1; @(posedge clk); #1; start[s] = 1'b0; end
        end
        valid[s] = 1'b0;
        n = 0;
        while (!done[s] && n < 300) begin @(negedge clk); n++; end
        t_done = $time;
        check("done_set", 64'(done[s]), 64'd1);
        check("busy_clear", 64'(busy[s]), 64'd0);
        check("setup_low_done", 64'(setup[s]), 64'd0);
        check("chain_content", (s == 0) ? 64'(chain0) : 64'(chain1), exp_chain);
        check("setup_cycles", 64'(sc[s] - base), 64'(cbits));
        if (chk_lat) check("done_latency", 64'((t_done - t_load) / 10), 64'(nb + cbits));
        @(negedge clk);
        check("done_held", 64'(done[s]), 64'd1);
        check("queues_drained", 64'(qsize(s)), 64'd0);
    endtask

    task automatic rand_stim();
        for (int i = 0; i < 8; i++) stim[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        logic [63:0] saved;
        int          s, nb, st, sl, sa;
        reset = 1'b1; start = '0; valid = '0; din[0] = '0; din[1] = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", 64'(rdy[i]), 64'd0);
            check("rst_setup", 64'(setup[i]), 64'd0);
            check("rst_param_out", 64'(pout[i]), 64'd0);
            check("rst_busy", 64'(busy[i]), 64'd0);
            check("rst_done", 64'(done[i]), 64'd0);
            check("rst_rb", 64'({rbv[i], rbd[i]}), 64'd0);
        end
        reset = 1'b0;

        // Bytes offered while idle must not be taken.
        valid[0] = 1'b1; din[0] = 8'h3C;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready", 64'(rdy[0]), 64'd0);
            check("idle_setup", 64'(setup[0]), 64'd0);
        end
        valid[0] = 1'b0;

        // Single neuron: 0xA5, 0xE0 gives bias 5 and weights 0x2F.
        stim[0] = 8'hA5; stim[1] = 8'hE0;
        do_load(1, -1, 0, -1, 1'b1);
        check("n1_bias", 64'(chain1[10:8]), 64'd5);
        check("n1_weights", 64'(chain1[7:0]), 64'h2F);
        stim[0] = 8'h00; stim[1] = 8'h00;
        do_load(1, -1, 0, -1, 1'b1);

        // Six 0xFF bytes fill the 44-bit chain with ones.
        for (int i = 0; i < 8; i++) stim[i] = 8'hFF;
        do_load(0, -1, 0, -1, 1'b1);
        check("all_ones", 64'(chain0), (64'd1 << C0) - 64'd1);

        // Stall between bytes 2 and 3 must not change the result.
        rand_stim();
        do_load(0, -1, 0, -1, 1'b1);
        saved = 64'(chain0);
        for (int i = 0; i < 6; i++) stim[i] = ~stim[i];
        do_load(0, -1, 0, -1, 1'b1);
        for (int i = 0; i < 6; i++) stim[i] = ~stim[i];
        do_load(0, 2, 5, -1, 1'b0);
        check("stall_same_chain", 64'(chain0), saved);

        // Start pulsed during shifting of byte 3 is ignored.
        rand_stim();
        do_load(0, -1, 0, 2, 1'b1);

        // Reset in the 4th shift cycle of byte 2.
        rand_stim();
`ifdef PARAM_READBACK_EN
        push_rb(0, C0);
`endif
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        for (int b = 7; b >= 0; b--) push_bit(0, stim[0][b]);
        drive_byte(0, stim[0]);
        for (int b = 7; b >= 0; b--) push_bit(0, stim[1][b]);
        drive_byte(0, stim[1]);
        valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_setup", 64'(setup[0]), 64'd0);
        check("midrst_busy", 64'(busy[0]), 64'd0);
        check("midrst_done", 64'(done[0]), 64'd0);
        check("midrst_ready", 64'(rdy[0]), 64'd0);
        check("midrst_pending_bits", 64'(q0.size()), 64'd4);
        q0.delete();
        rq0.delete();
        rand_stim();
        do_load(0, -1, 0, -1, 1'b1);

        // Randomized loads on both instances.
        repeat (20) begin
            s  = int'($urandom_range(0, 1));
            nb = (s == 0) ? 6 : 2;
            st = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, nb - 1)) : -1;
            sl = int'($urandom_range(1, 6));
            sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nb - 1)) : -1;
            rand_stim();
            do_load(s, st, sl, sa, st < 0);
        end

`ifndef PARAM_READBACK_EN
        check("rb_data_zero", 64'(rb_nz), 64'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bnn_param_loader.md
Name: bnn_param_loader

Overview:
Setup sequencer for a daisy-chain of binary neurons. It accepts configuration bytes over a valid/ready stream and serialises them, one bit per clock, into the chain's serial parameter input, asserting the chain's setup strobe only on cycles that carry a valid bit. It counts exactly the number of bits the chain holds, then reports completion. It sits between the chip's input pins/host interface and the first neuron of the network.

Parameters:
NEURONS, 4, number of neurons in the chain
INPUTS, 8, weights per neuron
BIAS_BITS, 3, bias width per neuron
(derived) CHAIN_BITS = NEURONS*(INPUTS+BIAS_BITS), default 44; BIT_CNT_W = $clog2(CHAIN_BITS+1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a full chain load
in_data  input  8  configuration byte, MSB shifted first
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts byte this cycle
setup  output  1  chain shift enable (to every neuron's setup)
param_out  output  1  serial bit to first neuron's param_in
chain_in  input  1  param_out of last neuron (readback path)
busy  output  1  load in progress
done  output  1  full chain loaded; held until next start or reset
rb_data  output  8  readback byte (optional feature)
rb_valid  output  1  rb_data valid pulse (optional feature)

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE. Registers: 8-bit shift reg sr, byte bit counter (0..8), total bit counter sent (BIT_CNT_W).
- Reset: state IDLE, sr=0, counters=0; outputs setup=0, param_out=0, in_ready=0, busy=0, done=0, rb_valid=0, rb_data=0.
- IDLE/DONE: start=1 -> LOAD, sent=0, done cleared. Otherwise hold.
- LOAD: in_ready=1, busy=1, setup=0. On in_valid&in_ready: sr<=in_data, byte_bits<=min(8, CHAIN_BITS-sent); -> SHIFT next cycle.
- SHIFT: setup=1, busy=1, param_out=sr[7] (registered source only, no combinational input path). Each cycle: sr<=sr<<1, byte_bits--, sent++. When byte_bits reaches 1 this cycle: if sent+1==CHAIN_BITS -> DONE else -> LOAD.
- Bit order: first bit sent ends in the last neuron's bias MSB; last bit sent ends in the first neuron's weights[0].
- Final partial byte: only the upper (CHAIN_BITS mod 8) bits are shifted; lower bits ignored.
- Throughput: 1 accept cycle + up to 8 shift cycles per byte. setup is high for exactly CHAIN_BITS cycles per load, never high in LOAD, IDLE or DONE.
- DONE: done=1, busy=0, setup=0.
- start while busy (LOAD/SHIFT): ignored.
- in_valid in IDLE/DONE: not accepted (in_ready=0).
- Reset mid-load: next cycle IDLE, setup=0. Chain contents are partial and a new start is required.
- Stalled input (in_valid=0 in LOAD): wait indefinitely, setup=0, chain holds its contents.

Optional Feature:
Macro PARAM_READBACK_EN. When defined: on each SHIFT cycle, chain_in (the old chain content falling out of the tail) is shifted into an 8-bit collector LSB-first-in. rb_valid pulses one cycle with rb_data after each 8 collected bits. At the final partial group, the remaining bits are left-aligned with zero padding, and the pulse occurs in the cycle after the last shift. This lets the host read previous parameters out while loading new ones. When undefined: chain_in is unused and rb_data=0, rb_valid=0 constantly. Ports exist in both builds.

Decomposition:
- Shared package bnn_pkg: state encodings (IDLE=0, LOAD=1, SHIFT=2, DONE=3) and a CHAIN_BITS computation function reused by the top level and testbench.
- One natural sub-module, bnn_readback_collector: the chain_in collector and the rb_valid generator, instantiated only under PARAM_READBACK_EN.

Test Plan:
- NEURONS=1 (11 bits), start, then bytes 0xA5, 0xE0 -> setup high 11 cycles; param_out sequence 1,0,1,0,0,1,0,1,1,1,1; attached neuron ends with weights=0x2F, bias=5; done=1.
- Default (44 bits), 6 bytes of 0xFF -> exactly 6 handshakes; setup high 44 cycles total; done asserts 50 cycles after the first LOAD cycle with no stalls; low 4 bits of byte 6 ignored.
- in_valid dropped for 5 cycles between bytes 2 and 3 -> setup=0 and in_ready=1 throughout the gap; final chain content identical to the no-stall run.
- start pulsed during SHIFT of byte 3 -> ignored; sent count and total still 44.
- reset asserted in the 4th SHIFT cycle -> next cycle state IDLE, setup=0, busy=0, done=0; a fresh start then loads correctly.
- PARAM_READBACK_EN, NEURONS=1: preload chain with 0x2F/5, then reload with 0x00,0x00 -> rb_data pulses 0xA5, then 0xE0.
